// File: rtl/sync_counter_pkg.sv
// rtl/sync_counter_pkg.sv - shared types and defaults for the synchronous counter family
package sync_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sync_down_counter.sv
// rtl/sync_down_counter.sv - loadable down counter/timer with terminal-count pulse and auto-reload
module sync_down_counter
    import sync_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] COUNT_ZERO = '0;
    localparam logic [WIDTH-1:0] COUNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload_reg;
    logic             tc_reg;
    logic             busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= COUNT_ZERO;
            reload_reg <= COUNT_ZERO;
            tc_reg     <= 1'b0;
            busy_reg   <= 1'b0;
        end else if (load) begin
            // A zero load is treated as "nothing to time" and parks in IDLE.
            count      <= load_val;
            reload_reg <= load_val;
            tc_reg     <= 1'b0;
            if (load_val != COUNT_ZERO) begin
                state    <= RUN;
                busy_reg <= 1'b1;
            end else begin
                state    <= IDLE;
                busy_reg <= 1'b0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    tc_reg <= 1'b0;
                end
                RUN: begin
                    tc_reg <= 1'b0;
                    if (en) begin
                        if (count > COUNT_ONE) begin
                            count <= count - COUNT_ONE;
                        end else if (count == COUNT_ONE) begin
                            count  <= COUNT_ZERO;
                            tc_reg <= 1'b1;
                            state  <= DONE;
                        end else begin
                            // Unreachable in normal operation; recover instead of wrapping.
                            state    <= IDLE;
                            busy_reg <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    tc_reg <= 1'b0;
                    if (auto_reload && (reload_reg != COUNT_ZERO)) begin
                        count <= reload_reg;
                        state <= RUN;
                    end else begin
                        state    <= IDLE;
                        busy_reg <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    count    <= COUNT_ZERO;
                    tc_reg   <= 1'b0;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign q    = count;
    assign zero = (count == COUNT_ZERO);
    assign tc   = tc_reg;
    assign busy = busy_reg;

endmodule
